// File: rtl/carrier_sense_gate.sv
// Carrier-sense transmit gate: holds a pending TX request until the channel has
// read idle for rssi_wait clocks, then grants the TX path until the packet ends.
module carrier_sense_gate #(
    parameter int RSSI_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RSSI_W-1:0] rssi,
    input  logic              rssi_valid,
    input  logic [31:0]       threshhold,
    input  logic [31:0]       rssi_wait,
    input  logic              tx_req,
    input  logic              tx_done,
    output logic              tx_grant,
    output logic              channel_busy,
    output logic [15:0]       defer_count,
    output logic [15:0]       debugbus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SENSE = 2'd1,
        TX    = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        clear;
    logic        defer_hit, deferred_q;
    logic [31:0] idle_cnt;
    logic        unused_thr;

    assign unused_thr = ^threshhold[30:RSSI_W];

    // A fresh sample overrides the held flag; idle_cnt follows the value being registered
    assign busy_d = rssi_valid ? (rssi >= threshhold[RSSI_W-1:0]) : busy_q;
    assign clear  = ~threshhold[31] | (~busy_q & (idle_cnt >= rssi_wait));

    always_comb begin
        state_d   = state_q;
        defer_hit = 1'b0;
        case (state_q)
            IDLE: if (tx_req) state_d = SENSE;
            SENSE: begin
                if (!tx_req)    state_d = IDLE;
                else if (clear) state_d = TX;
                else            defer_hit = 1'b1;
            end
            TX:   if (tx_done || !tx_req) state_d = HOLD;
            HOLD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tx_grant    <= 1'b0;
            busy_q      <= 1'b0;
            idle_cnt    <= '0;
            defer_count <= '0;
            deferred_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_grant <= (state_d == TX);
            busy_q   <= busy_d;
            if (busy_d || state_q == TX)
                idle_cnt <= '0;
            else if (idle_cnt != 32'hFFFF_FFFF)
                idle_cnt <= idle_cnt + 32'd1;
            // Count a deferral once per request, not once per waiting cycle
            if (defer_hit && !deferred_q && defer_count != 16'hFFFF)
                defer_count <= defer_count + 16'd1;
            deferred_q <= (state_d == SENSE) && (deferred_q || defer_hit);
        end
    end

    assign channel_busy = busy_q;
    assign debugbus     = {state_q, tx_req, tx_done, tx_grant, busy_q, clear,
                           rssi_valid, idle_cnt[7:0]};

endmodule

// File: tb/tb_carrier_sense_gate.sv
// Directed bench for carrier_sense_gate: bypass, idle wait, boundaries,
// repeated busy, back-to-back packets, async reset and deferral saturation.
module tb_carrier_sense_gate;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rssi;
    logic        rssi_valid;
    logic [31:0] threshhold;
    logic [31:0] rssi_wait;
    logic        tx_req;
    logic        tx_done;
    logic        tx_grant;
    logic        channel_busy;
    logic [15:0] defer_count;
    logic [15:0] debugbus;

    int total = 0;
    int bad   = 0;

    carrier_sense_gate #(.RSSI_W(16)) dut (
        .clk(clk), .reset(reset), .rssi(rssi), .rssi_valid(rssi_valid),
        .threshhold(threshhold), .rssi_wait(rssi_wait), .tx_req(tx_req),
        .tx_done(tx_done), .tx_grant(tx_grant), .channel_busy(channel_busy),
        .defer_count(defer_count), .debugbus(debugbus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; rssi = '0; rssi_valid = 1'b0; threshhold = '0;
        rssi_wait = '0; tx_req = 1'b0; tx_done = 1'b0;
        tick(); tick();
        chk("rst_grant", 32'(tx_grant), 32'd0);
        chk("rst_busy", 32'(channel_busy), 32'd0);
        chk("rst_defer", 32'(defer_count), 32'd0);
        chk("rst_debug", 32'(debugbus), 32'h0200);
        reset = 1'b1;
        tick();

        // bypass: grant two clocks after request, drop one clock after done
        tx_req = 1'b1;
        tick(); chk("byp_sense_grant", 32'(tx_grant), 32'd0);
        chk("byp_sense_state", 32'(debugbus[15:14]), 32'd1);
        tick(); chk("byp_tx_grant", 32'(tx_grant), 32'd1);
        chk("byp_tx_state", 32'(debugbus[15:14]), 32'd2);
        tx_done = 1'b1; tx_req = 1'b0;
        tick(); tx_done = 1'b0;
        chk("byp_done_grant", 32'(tx_grant), 32'd0);
        chk("byp_hold_state", 32'(debugbus[15:14]), 32'd3);
        tick(); chk("byp_idle_state", 32'(debugbus[15:14]), 32'd0);
        chk("byp_defer", 32'(defer_count), 32'd0);

        // idle wait of 10 after a single busy sample
        threshhold = 32'h8000_0100; rssi_wait = 32'd10;
        rssi = 16'h0200; rssi_valid = 1'b1; tx_req = 1'b1;
        tick();
        chk("iw_busy", 32'(channel_busy), 32'd1);
        chk("iw_idle0", 32'(debugbus[7:0]), 32'd0);
        rssi = 16'h0010;
        for (int i = 1; i <= 10; i++) begin
            tick(); chk($sformatf("iw_wait%0d", i), 32'(tx_grant), 32'd0);
        end
        chk("iw_idle10", 32'(debugbus[7:0]), 32'd10);
        chk("iw_busy_low", 32'(channel_busy), 32'd0);
        chk("iw_defer", 32'(defer_count), 32'd1);
        tick(); chk("iw_grant", 32'(tx_grant), 32'd1);
        tx_done = 1'b1; tx_req = 1'b0;
        tick(); tx_done = 1'b0;
        chk("iw_done", 32'(tx_grant), 32'd0);
        tick();

        // equal-to-threshold is busy; zero wait grants immediately when quiet
        rssi = 16'h0100;
        tick(); chk("eq_busy", 32'(channel_busy), 32'd1);
        rssi = 16'h0010; rssi_wait = 32'd0;
        tick(); chk("eq_quiet", 32'(channel_busy), 32'd0);
        rssi_valid = 1'b0; tx_req = 1'b1;
        tick(); chk("w0_sense", 32'(tx_grant), 32'd0);
        tick(); chk("w0_grant", 32'(tx_grant), 32'd1);
        chk("w0_defer", 32'(defer_count), 32'd1);
        tx_done = 1'b1; tx_req = 1'b0;
        tick(); tx_done = 1'b0;
        tick();

        // busy every 5 clocks never satisfies a wait of 8
        rssi_wait = 32'd8; tx_req = 1'b1; rssi_valid = 1'b1;
        for (int j = 0; j < 16; j++) begin
            rssi = (j % 5 == 0) ? 16'h0200 : 16'h0010;
            tick(); chk($sformatf("rep_nogrant%0d", j), 32'(tx_grant), 32'd0);
        end
        rssi = 16'h0010;
        for (int i = 1; i <= 8; i++) begin
            tick(); chk($sformatf("rep_wait%0d", i), 32'(tx_grant), 32'd0);
        end
        tick(); chk("rep_grant", 32'(tx_grant), 32'd1);
        chk("rep_defer", 32'(defer_count), 32'd2);
        tx_done = 1'b1; tx_req = 1'b0;
        tick(); tx_done = 1'b0;
        tick();

        // withdraw request while deferring
        rssi = 16'h0200; tx_req = 1'b1;
        tick(); rssi = 16'h0010;
        tick(); chk("wd_sense", 32'(debugbus[15:14]), 32'd1);
        chk("wd_defer", 32'(defer_count), 32'd3);
        tx_req = 1'b0;
        tick(); chk("wd_idle", 32'(debugbus[15:14]), 32'd0);
        chk("wd_grant", 32'(tx_grant), 32'd0);
        rssi_valid = 1'b0;

        // stray done outside TX
        tx_done = 1'b1;
        tick(); tx_done = 1'b0;
        chk("stray_done", 32'(debugbus[15:14]), 32'd0);

        // back-to-back with request held, busy sample during TX
        rssi_wait = 32'd0; rssi = 16'h0010; rssi_valid = 1'b1;
        tick(); rssi_valid = 1'b0; tx_req = 1'b1;
        tick();
        tick(); chk("b2b_grant1", 32'(tx_grant), 32'd1);
        rssi = 16'h0200; rssi_valid = 1'b1;
        tick(); chk("b2b_busy_keep", 32'(tx_grant), 32'd1);
        chk("b2b_busy_flag", 32'(channel_busy), 32'd1);
        rssi = 16'h0010; tx_done = 1'b1;
        tick(); tx_done = 1'b0; rssi_valid = 1'b0;
        chk("b2b_gap_hold", 32'(tx_grant), 32'd0);
        tick(); chk("b2b_gap_idle", 32'(tx_grant), 32'd0);
        chk("b2b_idle_state", 32'(debugbus[15:14]), 32'd0);
        tick(); chk("b2b_gap_sense", 32'(tx_grant), 32'd0);
        tick(); chk("b2b_grant2", 32'(tx_grant), 32'd1);

        // asynchronous reset mid-TX
        reset = 1'b0;
        #2;
        chk("ar_grant", 32'(tx_grant), 32'd0);
        chk("ar_defer", 32'(defer_count), 32'd0);
        chk("ar_idle", 32'(debugbus[7:0]), 32'd0);
        chk("ar_state", 32'(debugbus[15:14]), 32'd0);
        tick();
        reset = 1'b1;
        tick(); chk("ar_first_edge", 32'(debugbus[15:14]), 32'd1);
        tx_req = 1'b0;
        tick();

        // deferral counter saturation
        force dut.defer_count = 16'hFFFF;
        #1;
        release dut.defer_count;
        chk("sat_preset", 32'(defer_count), 32'hFFFF);
        rssi = 16'h0200; rssi_valid = 1'b1; tx_req = 1'b1;
        tick(); rssi_valid = 1'b0;
        tick(); chk("sat_state", 32'(debugbus[15:14]), 32'd1);
        chk("sat_hold", 32'(defer_count), 32'hFFFF);
        tx_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
